// File: rtl/cache_axi_arbiter_pkg.sv
// cache_axi_pkg: shared FSM states, owner encoding and bridge request type for cache_axi_arbiter.
// No ports. Exports state_t (IDLE/ISSUE/WAIT_R/WAIT_B), owner_t (OWN_IR/OWN_DR/OWN_DW), LINE_TYPE.
package cache_axi_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, WAIT_B} state_t;
  typedef enum logic [1:0] {OWN_IR = 2'd0, OWN_DR = 2'd1, OWN_DW = 2'd2} owner_t;
  localparam logic [2:0] LINE_TYPE = 3'b100;
endpackage

// File: rtl/cache_axi_arbiter_age_counter.sv
// arb_age_counter: saturating count of arbitrations the ICache read has lost while waiting.
// Ports: clk, resetn (async active-low), inc (ir lost an arbitration), clr (ir won), hit (age == LIM).
module arb_age_counter #(
  parameter int LIM = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  logic [3:0] age;
  assign hit = age == 4'(LIM);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) age <= '0;
    else if (clr) age <= '0;
    else if (inc && !hit) age <= age + 4'd1;
  end
endmodule

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: grants the single bridge request port to ICache read, DCache read or DCache write.
// Ports: clk/resetn (async active-low); ir_*, dr_*, dw_* requester handshakes; ret_* shared return beat;
// br_* bridge request and response; arb_err sticky watchdog error.
// Optional watchdog enabled by defining CACHE_AXI_ARB_TIMEOUT_EN; otherwise arb_err is tied to 0.
module cache_axi_arbiter
  import cache_axi_pkg::*;
#(
  parameter int STARVE_LIM  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ir_req,
  input  logic [31:0]  ir_addr,
  output logic         ir_rdy,
  output logic         ir_ret_valid,
  input  logic         dr_req,
  input  logic [31:0]  dr_addr,
  output logic         dr_rdy,
  output logic         dr_ret_valid,
  input  logic         dw_req,
  input  logic [31:0]  dw_addr,
  input  logic [3:0]   dw_wstrb,
  input  logic [127:0] dw_data,
  output logic         dw_rdy,
  output logic         dw_done,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  output logic         br_req,
  output logic         br_wr,
  output logic [2:0]   br_type,
  output logic [31:0]  br_addr,
  output logic [3:0]   br_wstrb,
  output logic [127:0] br_wdata,
  input  logic         br_rdy,
  input  logic         br_ret_valid,
  input  logic         br_ret_last,
  input  logic [31:0]  br_ret_data,
  input  logic         br_wr_done,
  output logic         arb_err
);
  if (STARVE_LIM < 1 || STARVE_LIM > 15 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("cache_axi_arbiter: parameter out of range");
  end
  state_t state;
  owner_t owner, win;
  logic grant, hit, tout, in_r;
  // Gating with resetn keeps every rdy low while reset is held.
  assign grant = resetn && state == IDLE && (ir_req || dr_req || dw_req);
  // A write to the same line as a simultaneous read wins through plain dw > dr priority.
  always_comb win = (hit && ir_req) ? OWN_IR : dw_req ? OWN_DW : dr_req ? OWN_DR : OWN_IR;
  assign ir_rdy = grant && win == OWN_IR;
  assign dr_rdy = grant && win == OWN_DR;
  assign dw_rdy = grant && win == OWN_DW;
  arb_age_counter #(.LIM(STARVE_LIM)) u_age (
    .clk    (clk),
    .resetn (resetn),
    .inc    (grant && ir_req && win != OWN_IR),
    .clr    (ir_rdy),
    .hit    (hit)
  );
  // Responses outside the matching wait state are stray and must not reach a requester.
  assign in_r         = state == WAIT_R;
  assign ir_ret_valid = in_r && owner == OWN_IR && br_ret_valid;
  assign dr_ret_valid = in_r && owner == OWN_DR && br_ret_valid;
  assign ret_last     = in_r && br_ret_last;
  assign ret_data     = in_r ? br_ret_data : '0;
  assign dw_done      = state == WAIT_B && br_wr_done;
  assign br_type      = LINE_TYPE;
`ifdef CACHE_AXI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign tout = state != IDLE && tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcnt    <= '0;
      arb_err <= 1'b0;
    end else begin
      tcnt <= (state == IDLE || tout) ? '0 : tcnt + TW'(1);
      if (tout) arb_err <= 1'b1;
    end
  end
`else
  assign tout    = 1'b0;
  assign arb_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      owner    <= OWN_IR;
      br_req   <= 1'b0;
      br_wr    <= 1'b0;
      br_addr  <= '0;
      br_wstrb <= '0;
      br_wdata <= '0;
    end else if (tout) begin
      state  <= IDLE;
      br_req <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state    <= ISSUE;
          owner    <= win;
          br_req   <= 1'b1;
          br_wr    <= win == OWN_DW;
          br_addr  <= win == OWN_DW ? dw_addr : win == OWN_DR ? dr_addr : ir_addr;
          br_wstrb <= win == OWN_DW ? dw_wstrb : '0;
          br_wdata <= win == OWN_DW ? dw_data : '0;
        end
        ISSUE: if (br_rdy) begin
          br_req <= 1'b0;
          state  <= br_wr ? WAIT_B : WAIT_R;
        end
        WAIT_R: if (br_ret_valid && br_ret_last) state <= IDLE;
        WAIT_B: if (br_wr_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cache_axi_arbiter.md
Name: cache_axi_arbiter

Overview:
- Sequences the single cache-side request port of the SRAM-to-AXI bridge among three requesters: ICache line read, DCache line read, DCache line write (victim writeback).
- One transaction is outstanding at a time. The grant is locked from acceptance until the transaction completes.
- Read return beats and write completion are routed back to the owning requester.
- Sits between the ICache/DCache miss interfaces and the bridge.

Parameters:
STARVE_LIM, 4, consecutive lost arbitrations after which a waiting ICache read is forced to win once (1..15)
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ir_req  in  1  ICache read request; held until ir_rdy
ir_addr  in  32  ICache line address
ir_rdy  out  1  ICache request accepted this cycle
ir_ret_valid  out  1  return beat for ICache
dr_req  in  1  DCache read request
dr_addr  in  32  DCache read address
dr_rdy  out  1  DCache read accepted
dr_ret_valid  out  1  return beat for DCache
dw_req  in  1  DCache write request
dw_addr  in  32  write address
dw_wstrb  in  4  write strobe
dw_data  in  128  write line
dw_rdy  out  1  write accepted
dw_done  out  1  one-cycle pulse: write response received
ret_last  out  1  last beat (shared)
ret_data  out  32  beat data (shared)
br_req  out  1  request to bridge
br_wr  out  1  1=write, 0=read
br_type  out  3  always 3'b100 (line)
br_addr  out  32  granted address
br_wstrb  out  4  granted strobe
br_wdata  out  128  granted line
br_rdy  in  1  bridge accepts request
br_ret_valid  in  1  bridge read beat
br_ret_last  in  1  bridge last beat
br_ret_data  in  32  bridge beat data
br_wr_done  in  1  bridge write response (bvalid&&bready)
arb_err  out  1  watchdog error, sticky (tied 0 without the optional feature)

Behaviour:
- States: IDLE, ISSUE, WAIT_R, WAIT_B. Reset state is IDLE. All outputs reset to 0; owner and age counter reset to 0.
- IDLE: if any request is pending, select the winner combinationally and assert that requester's rdy in the same cycle. Latch owner, wr, addr, wstrb and wdata. Next state is ISSUE. The requester drops its req after seeing rdy.
- Priority: dw > dr > ir. Override: if age == STARVE_LIM and ir_req is pending, ir wins and age clears.
- Age counter:
  - ir wins: age clears.
  - ir_req pending and another requester wins: age increments, saturating at STARVE_LIM.
  - ir_req idle: age holds.
- Simultaneous dw_req and dr_req to the same 16B-aligned line: dw wins (write-before-read ordering).
- ISSUE: br_req=1 with the latched fields. It stays asserted until the cycle where br_rdy=1. On that edge go to WAIT_R (read) or WAIT_B (write). Minimum latency from req to br_req is 1 cycle.
- WAIT_R:
  - Assert ir_ret_valid or dr_ret_valid = br_ret_valid, per owner. ret_data and ret_last pass through combinationally.
  - br_ret_valid && br_ret_last: return to IDLE.
  - A new grant may be issued on the cycle after last.
- WAIT_B: on br_wr_done, assert dw_done for 1 cycle and go to IDLE.
- Returns or wr_done arriving in IDLE or ISSUE are ignored; no ret_valid or done is produced.
- Reset asserted mid-transaction: immediate return to IDLE with the owner cleared. Stray beats after reset are ignored as above.
- ir_rdy, dr_rdy and dw_rdy are one-hot or all zero, and are never high outside IDLE.

Optional Feature:
- Macro: CACHE_AXI_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE, WAIT_R and WAIT_B and clears in IDLE.
  - Reaching TIMEOUT_CYC sets arb_err (sticky until reset) and forces IDLE.
- Undefined: no counter is built; arb_err is tied to 0.

Decomposition:
- Package cache_axi_pkg:
  - state enum (IDLE/ISSUE/WAIT_R/WAIT_B)
  - owner encoding (OWN_IR=2'd0, OWN_DR=2'd1, OWN_DW=2'd2)
  - LINE_TYPE=3'b100
- Sub-module arb_age_counter: saturating starvation counter, with inputs inc/clr and output hit.

Test Plan:
- ir_req only, addr 0x1c000000 → ir_rdy at cycle 0; br_req at cycle 1 with br_wr=0 until br_rdy; 4 beats routed to ir_ret_valid; ret_last on beat 4; return to IDLE.
- dr_req, dw_req and ir_req asserted together → dw wins. After dw_done, dr wins. ir wins third.
- Continuous dr_req traffic with ir_req held, STARVE_LIM=4 → ir loses 4 arbitrations and wins the 5th.
- dw to 0x100 while dr to 0x104 in the same cycle → write granted first. dw_done pulses 1 cycle on br_wr_done before the read issues.
- resetn low during WAIT_R after 2 beats → all outputs 0. Following 2 stray br_ret_valid beats produce no ret_valid.
- With CACHE_AXI_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: br_rdy is never asserted → arb_err=1 at cycle 16, state returns to IDLE, and arb_err stays high until reset.
